// File: rtl/lcd_cmd_ctrl.sv
// HD44780-style LCD command controller: buffers {rs, byte} writes in a FIFO and
// replays each as a timed enable strobe (one strobe in 8-bit mode, two in 4-bit mode).
//
// state     | meaning
// IDLE      | waiting for a queued command
// SETUP     | rs/data driven, lcd_en low, setup time running
// EN_HI     | lcd_en high
// HOLD      | lcd_en low for one clock, rs/data unchanged
// GAP       | 4-bit mode only: low nibble driven before the second strobe
// WAIT_EXEC | LCD execution time before the next command
module lcd_cmd_ctrl #(
  parameter int unsigned DATA_4BIT     = 0,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned SETUP_CYC     = 4,
  parameter int unsigned EN_CYC        = 12,
  parameter int unsigned EXEC_CYC      = 2000,
  parameter int unsigned LONG_EXEC_CYC = 80000
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic                            wr_rs,
  input  logic [7:0]                      wr_data,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [7:0]                      lcd_data,
  output logic                            lcd_rs,
  output logic                            lcd_rw,
  output logic                            lcd_en
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned MAX_A   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int unsigned MAX_B   = (EXEC_CYC > LONG_EXEC_CYC) ? EXEC_CYC : LONG_EXEC_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_EXEC_CYC - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    EN_HI     = 3'd2,
    HOLD      = 3'd3,
    GAP       = 3'd4,
    WAIT_EXEC = 3'd5
  } state_t;

  state_t             state_q, state_next;
  logic [CNT_W-1:0]   cnt_q, cnt_next;
  logic [8:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic               avail_q;
  logic [8:0]         cmd_q, cmd_next;
  logic               nib2_q, nib2_next;
  logic [7:0]         data_next;
  logic               rs_next;
  logic               en_next;
  logic               push, pop;
  logic               is_long;
  logic [8:0]         head;

  assign wr_ready = (fifo_level < LVL_W'(FIFO_DEPTH));
  assign push     = wr_valid && wr_ready;
  assign head     = mem[rd_ptr_q];
  assign busy     = !((state_q == IDLE) && (fifo_level == '0));
  assign lcd_rw   = 1'b0;
  assign is_long  = !cmd_q[8] && ((cmd_q[7:0] == 8'h01) || (cmd_q[7:0] == 8'h02) ||
                                  (cmd_q[7:0] == 8'h03));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {wr_rs, wr_data};
  end

  // avail_q lags the level by one clock, so a write into an empty FIFO
  // reaches the bus two edges after it is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_level <= '0;
      avail_q    <= 1'b0;
    end else begin
      avail_q <= (fifo_level != '0);
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cmd_q    <= '0;
      nib2_q   <= 1'b0;
      lcd_data <= 8'h00;
      lcd_rs   <= 1'b0;
      lcd_en   <= 1'b0;
    end else begin
      state_q  <= state_next;
      cnt_q    <= cnt_next;
      cmd_q    <= cmd_next;
      nib2_q   <= nib2_next;
      lcd_data <= data_next;
      lcd_rs   <= rs_next;
      lcd_en   <= en_next;
    end
  end

  always_comb begin
    state_next = state_q;
    cnt_next   = cnt_q;
    cmd_next   = cmd_q;
    nib2_next  = nib2_q;
    data_next  = lcd_data;
    rs_next    = lcd_rs;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (avail_q && (fifo_level != '0)) begin
          pop        = 1'b1;
          cmd_next   = head;
          nib2_next  = 1'b0;
          rs_next    = head[8];
          data_next  = (DATA_4BIT != 0) ? {head[7:4], 4'h0} : head[7:0];
          state_next = SETUP;
          cnt_next   = SETUP_LD;
        end
      end
      SETUP, GAP: begin
        if (cnt_q == '0) begin
          state_next = EN_HI;
          cnt_next   = EN_LD;
        end else begin
          cnt_next = cnt_q - 1'b1;
        end
      end
      EN_HI: begin
        if (cnt_q == '0) begin
          state_next = HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if ((DATA_4BIT != 0) && !nib2_q) begin
          state_next = GAP;
          nib2_next  = 1'b1;
          data_next  = {cmd_q[3:0], 4'h0};
          cnt_next   = SETUP_LD;
        end else begin
          state_next = WAIT_EXEC;
          cnt_next   = is_long ? LONG_LD : EXEC_LD;
        end
      end
      WAIT_EXEC: begin
        if (cnt_q == '0) state_next = IDLE;
        else             cnt_next   = cnt_q - 1'b1;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    en_next = (state_next == EN_HI);
  end

endmodule

// File: tb/tb_lcd_cmd_ctrl.sv
// Directed bench for lcd_cmd_ctrl: one 8-bit and one 4-bit instance with short timing
// parameters; expected edge-by-edge timelines are written out by hand.
module tb_lcd_cmd_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_valid8, wr_rs8, wr_ready8, busy8, lcd_rs8, lcd_rw8, lcd_en8;
  logic [7:0] wr_data8, lcd_data8;
  logic [2:0] fifo_level8;
  logic       wr_valid4, wr_rs4, wr_ready4, busy4, lcd_rs4, lcd_rw4, lcd_en4;
  logic [7:0] wr_data4, lcd_data4;
  logic [2:0] fifo_level4;

  int checks   = 0;
  int failures = 0;
  logic [7:0] strobes[$];
  logic       pen8, pen4;
  logic [8:0] pbus8, pbus4;

  always #5 clk = ~clk;

  lcd_cmd_ctrl #(.DATA_4BIT(0), .FIFO_DEPTH(4), .SETUP_CYC(2), .EN_CYC(3),
                 .EXEC_CYC(5), .LONG_EXEC_CYC(20)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid8), .wr_ready(wr_ready8),
    .wr_rs(wr_rs8), .wr_data(wr_data8), .busy(busy8), .fifo_level(fifo_level8),
    .lcd_data(lcd_data8), .lcd_rs(lcd_rs8), .lcd_rw(lcd_rw8), .lcd_en(lcd_en8));

  lcd_cmd_ctrl #(.DATA_4BIT(1), .FIFO_DEPTH(4), .SETUP_CYC(2), .EN_CYC(3),
                 .EXEC_CYC(5), .LONG_EXEC_CYC(20)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid4), .wr_ready(wr_ready4),
    .wr_rs(wr_rs4), .wr_data(wr_data4), .busy(busy4), .fifo_level(fifo_level4),
    .lcd_data(lcd_data4), .lcd_rs(lcd_rs4), .lcd_rw(lcd_rw4), .lcd_en(lcd_en4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Bus must stay frozen while lcd_en is high and in the clock after it falls.
  always @(negedge clk) begin
    if (!reset_n) begin
      pen8 <= 1'b0;
      pen4 <= 1'b0;
    end else begin
      chk("rw8", lcd_rw8, 0);
      chk("rw4", lcd_rw4, 0);
      if (lcd_en8 || pen8) chk("bus8_stable", {lcd_rs8, lcd_data8}, pbus8);
      if (lcd_en4 || pen4) chk("bus4_stable", {lcd_rs4, lcd_data4}, pbus4);
      if (lcd_en8 && !pen8) strobes.push_back(lcd_data8);
      pen8 <= lcd_en8;
      pen4 <= lcd_en4;
    end
    pbus8 <= {lcd_rs8, lcd_data8};
    pbus4 <= {lcd_rs4, lcd_data4};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write8(input logic rs, input logic [7:0] d);
    wr_rs8    = rs;
    wr_data8  = d;
    wr_valid8 = 1'b1;
    @(posedge clk);
    #1;
    wr_valid8 = 1'b0;
  endtask

  // Single 0x41 data write from idle: edge-by-edge timeline relative to accept edge T.
  task automatic single_write_check();
    write8(1'b1, 8'h41);
    chk("sw_level_T", fifo_level8, 1);
    chk("sw_busy_T", busy8, 1);
    tick();
    chk("sw_data_T1", lcd_data8, 8'h00);
    tick();
    chk("sw_data_T2", lcd_data8, 8'h41);
    chk("sw_rs_T2", lcd_rs8, 1);
    chk("sw_en_T2", lcd_en8, 0);
    chk("sw_level_T2", fifo_level8, 0);
    for (int k = 3; k <= 13; k++) begin
      tick();
      chk($sformatf("sw_en_T%0d", k), lcd_en8, (k >= 4 && k <= 6));
      chk($sformatf("sw_busy_T%0d", k), busy8, (k < 13));
      if (k == 7) chk("sw_hold_data", lcd_data8, 8'h41);
    end
  endtask

  task automatic timed_write(input logic rs, input logic [7:0] d, input int done_k);
    write8(rs, d);
    for (int k = 1; k < done_k; k++) tick();
    chk($sformatf("exec_busy_%0h_%0h_before", rs, d), busy8, 1);
    tick();
    chk($sformatf("exec_busy_%0h_%0h_after", rs, d), busy8, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    wr_valid8 = 1'b0; wr_rs8 = 1'b0; wr_data8 = 8'h00;
    wr_valid4 = 1'b0; wr_rs4 = 1'b0; wr_data4 = 8'h00;
    #12;
    chk("rst_level", fifo_level8, 0);
    chk("rst_ready", wr_ready8, 1);
    chk("rst_busy", busy8, 0);
    chk("rst_en", lcd_en8, 0);
    chk("rst_bus", {lcd_rs8, lcd_data8}, 0);
    chk("rst_rw", lcd_rw8, 0);
    reset_n = 1'b1;
    tick();
    tick();

    single_write_check();

    timed_write(1'b0, 8'h01, 28);
    timed_write(1'b1, 8'h01, 13);
    timed_write(1'b0, 8'h03, 28);
    timed_write(1'b0, 8'h02, 28);
    timed_write(1'b0, 8'h00, 13);
    timed_write(1'b0, 8'h04, 13);

    // 4-bit instance: 0xA5 as two nibble strobes
    wr_rs4 = 1'b1; wr_data4 = 8'hA5; wr_valid4 = 1'b1;
    @(posedge clk);
    #1;
    wr_valid4 = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      chk($sformatf("n4_data_T%0d", k), lcd_data4,
          (k < 2) ? 8'h00 : ((k < 8) ? 8'hA0 : 8'h50));
      chk($sformatf("n4_rs_T%0d", k), lcd_rs4, (k >= 2));
      chk($sformatf("n4_en_T%0d", k), lcd_en4,
          ((k >= 4 && k <= 6) || (k >= 10 && k <= 12)));
      chk($sformatf("n4_busy_T%0d", k), busy4, (k < 19));
    end

    // Six back-to-back writes with wr_valid held high
    strobes.delete();
    wr_rs8 = 1'b1;
    wr_valid8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data8 = 8'h10 + 8'(i);
      @(posedge clk);
      #1;
      chk($sformatf("b2b_level_%0d", i), fifo_level8, (i < 2) ? i + 1 : i);
      chk($sformatf("b2b_ready_%0d", i), wr_ready8, (i < 4));
    end
    wr_data8 = 8'h15;
    for (int k = 5; k <= 13; k++) tick();
    chk("b2b_full_level", fifo_level8, 4);
    chk("b2b_full_ready", wr_ready8, 0);
    tick();
    chk("b2b_pop_level", fifo_level8, 3);
    chk("b2b_pop_ready", wr_ready8, 1);
    tick();
    chk("b2b_6th_level", fifo_level8, 4);
    wr_valid8 = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (!busy8) break;
      tick();
    end
    chk("b2b_done_busy", busy8, 0);
    chk("b2b_count", strobes.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("b2b_order_%0d", i),
          (i < strobes.size()) ? {24'h0, strobes[i]} : 32'hDEAD, 8'h10 + 8'(i));

    // Reset during EN_HI with two entries queued
    write8(1'b1, 8'h21);
    write8(1'b1, 8'h22);
    write8(1'b1, 8'h23);
    tick();
    tick();
    chk("rmid_en_before", lcd_en8, 1);
    chk("rmid_level_before", fifo_level8, 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rmid_en", lcd_en8, 0);
    chk("rmid_level", fifo_level8, 0);
    chk("rmid_busy", busy8, 0);
    chk("rmid_ready", wr_ready8, 1);
    chk("rmid_bus", {lcd_rs8, lcd_data8}, 0);
    #10;
    reset_n = 1'b1;
    strobes.delete();
    for (int k = 0; k < 30; k++) tick();
    chk("rpost_no_strobe", strobes.size(), 0);
    chk("rpost_busy", busy8, 0);
    single_write_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_ctrl.md
LCD_CMD_CTRL -- requirements
Module: lcd_cmd_ctrl

Interface
REQ-001 Parameter: DATA_4BIT, 0, 1 selects HD44780 4-bit bus mode; 0 selects 8-bit mode.
REQ-002 Parameter: FIFO_DEPTH, 8, command FIFO entries; power of two, at least 2.
REQ-003 Parameter: SETUP_CYC, 4, clocks lcd_rs/lcd_data are stable before lcd_en rises; at least 1.
REQ-004 Parameter: EN_CYC, 12, clocks lcd_en is held high; at least 1.
REQ-005 Parameter: EXEC_CYC, 2000, post-transfer wait for normal commands and data; at least 1.
REQ-006 Parameter: LONG_EXEC_CYC, 80000, post-transfer wait for clear/home; at least 1.
REQ-007 Clock and reset: one clock, clk; reset is asynchronous and active-low, reset_n.
REQ-008 Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- wr_valid  in  1  command write request
- wr_ready  out  1  FIFO can accept a write
- wr_rs  in  1  0 = instruction, 1 = data
- wr_data  in  8  byte to send
- busy  out  1  FSM not IDLE or FIFO non-empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
- lcd_data  out  8  LCD data bus
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write; tied 0 (write only)
- lcd_en  out  1  LCD enable strobe

Function
REQ-009 A write is accepted on a rising edge where wr_valid=1 and wr_ready=1; it pushes {wr_rs, wr_data}.
REQ-010 wr_ready=1 iff fifo_level < FIFO_DEPTH; wr_valid is ignored when full (no overwrite, no error).
REQ-011 FIFO is first in, first out; read/write pointers wrap modulo FIFO_DEPTH.
REQ-012 A push and a pop in the same cycle leave fifo_level unchanged; at full, only a pop can occur.
REQ-013 FSM states: IDLE, SETUP, EN_HI, HOLD, GAP, WAIT_EXEC.
REQ-014 IDLE with FIFO non-empty: pop the head into the output registers, enter SETUP; the first SETUP cycle is 2 clocks after the accepting edge when the FIFO was empty.
REQ-015 SETUP lasts SETUP_CYC clocks, then EN_HI for EN_CYC clocks with lcd_en=1, then HOLD for 1 clock with lcd_en=0 and lcd_rs/lcd_data unchanged.
REQ-016 8-bit mode: lcd_data carries the full byte throughout SETUP, EN_HI and HOLD; after HOLD, enter WAIT_EXEC.
REQ-017 4-bit mode, first pass: lcd_data[7:4] carries the high nibble and lcd_data[3:0]=0.
REQ-018 4-bit mode, after the first HOLD: enter GAP for SETUP_CYC clocks with lcd_data[7:4] set to the low nibble, then EN_HI and HOLD again, then WAIT_EXEC.
REQ-019 WAIT_EXEC lasts LONG_EXEC_CYC when rs=0 and data is 0x01, 0x02 or 0x03; otherwise it lasts EXEC_CYC. It then returns to IDLE.
REQ-020 lcd_en is high only in EN_HI; it is never high in two consecutive transfers without at least SETUP_CYC+1 low cycles between them.
REQ-021 A single wait counter, sized for max(SETUP_CYC, EN_CYC, LONG_EXEC_CYC), is reloaded on each state entry.
REQ-022 lcd_rs, lcd_data and lcd_en are registered outputs (no combinational path from inputs); lcd_rw is a constant 0.
REQ-023 busy=0 iff state=IDLE and fifo_level=0.

Reset
REQ-024 reset_n=0 asynchronously forces: state IDLE, FIFO empty, counter 0, lcd_en=0, lcd_rs=0, lcd_data=0x00, fifo_level=0, wr_ready=1, busy=0.
REQ-025 Reset mid-transfer aborts it immediately; lcd_en drops in the same cycle; FIFO contents are discarded.
REQ-026 Operation resumes on the first rising edge after reset_n deasserts; there is no built-in LCD power-on initialisation sequence (software issues it).

Verification
Bench parameters: SETUP_CYC=2, EN_CYC=3, EXEC_CYC=5, LONG_EXEC_CYC=20, FIFO_DEPTH=4.
REQ-027 8-bit single write of rs=1, 0x41 at edge T -> lcd_rs=1 and lcd_data=0x41 from T+2; lcd_en high during T+4..T+6; HOLD at T+7; WAIT_EXEC 5 clocks; busy falls at T+13.
REQ-028 4-bit write of rs=1, 0xA5 -> first strobe with lcd_data=0xA0, then GAP of 2 clocks, second strobe with lcd_data=0x50, then a 5-clock wait.
REQ-029 Write of rs=0, 0x01 -> a 20-clock WAIT_EXEC; rs=1, 0x01 -> a 5-clock wait.
REQ-030 6 back-to-back writes with wr_valid held high -> 1 entry popped immediately, 4 buffered, wr_ready=0 at full; the 6th write is accepted only after the next pop; all 6 bytes appear in order.
REQ-031 reset_n pulsed low during EN_HI with 2 entries queued -> lcd_en=0 and fifo_level=0 immediately; no further strobes; a new write after release behaves as in REQ-027.
REQ-032 Checker: lcd_rs/lcd_data are never changed while lcd_en=1 or in HOLD; lcd_rw=0 at all times.
